logic_alu: RTL and testbench

Parametrised, registered successor to the team's two-input gate block: a WIDTH-bit bitwise logic unit with opcode-selected function, valid/ready handshakes on input and output, and an accumulate mode. In accumulate mode, a multi-beat packet is folded through the selected function into a single result. It sits between a stream producer and a consumer wherever bitwise combine, mask or reduce operations are needed, with registered outputs and backpressure.

---
 rtl/logic_pkg.sv | 20 ++
 rtl/logic_alu_if.sv | 29 ++
 rtl/logic_op_fn.sv | 26 ++
 rtl/logic_alu.sv | 88 ++++++++
 tb/tb_logic_alu.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared opcode and state types for the logic ALU
package logic_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_PASS_A = 3'd6,
        OP_NOT_A = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/logic_alu_if.sv
// rtl/logic_alu_if.sv - beat/result handshake bundle between producer, ALU and consumer
interface logic_alu_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] beats;

    modport master (
        output in_valid, a, b, op, acc_mode, last, out_ready,
        input  in_ready, out_valid, y, zero, parity, beats
    );

    modport slave (
        input  in_valid, a, b, op, acc_mode, last, out_ready,
        output in_ready, out_valid, y, zero, parity, beats
    );
endinterface

// File: rtl/logic_op_fn.sv
// rtl/logic_op_fn.sv - combinational bitwise function unit shared by both FSM states
module logic_op_fn
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] z,
    input  op_e              op,
    output logic [WIDTH-1:0] r
);
    always_comb begin
        r = '0;
        case (op)
            OP_AND:    r = x & z;
            OP_OR:     r = x | z;
            OP_NAND:   r = ~(x & z);
            OP_NOR:    r = ~(x | z);
            OP_XOR:    r = x ^ z;
            OP_XNOR:   r = ~(x ^ z);
            OP_PASS_A: r = x;
            OP_NOT_A:  r = ~x;
            default:   r = '0;
        endcase
    end
endmodule

// File: rtl/logic_alu.sv
// rtl/logic_alu.sv - registered bitwise ALU with handshakes and packet accumulate mode
module logic_alu
    import logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    logic_alu_if.slave bus
);
    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;

    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             parity_q;
    logic [CNT_W-1:0] beats_q;

    logic [WIDTH-1:0] fn_x;
    logic [WIDTH-1:0] fn_z;
    op_e              fn_op;
    logic [WIDTH-1:0] fn_r;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    // One function unit: live operands in IDLE, running fold in ACCUM
    assign fn_x  = (state == S_IDLE) ? bus.a : acc;
    assign fn_z  = (state == S_IDLE) ? bus.b : bus.a;
    assign fn_op = (state == S_IDLE) ? op_e'(bus.op) : op_q;

    logic_op_fn #(.WIDTH(WIDTH)) u_fn (
        .x  (fn_x),
        .z  (fn_z),
        .op (fn_op),
        .r  (fn_r)
    );

    assign bus.in_ready = rst_n && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign cnt_next     = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_q     <= OP_AND;
            valid_q  <= 1'b0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            beats_q  <= '0;
        end else begin
            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                if (state == S_IDLE && bus.acc_mode && !bus.last) begin
                    acc   <= fn_r;
                    op_q  <= op_e'(bus.op);
                    cnt   <= CNT_W'(1);
                    state <= S_ACCUM;
                end else if (state == S_ACCUM && !bus.last) begin
                    acc <= fn_r;
                    cnt <= cnt_next;
                end else begin
                    // Result load wins over the consumer accept on the same edge
                    valid_q  <= 1'b1;
                    y_q      <= fn_r;
                    zero_q   <= (fn_r == '0);
                    parity_q <= ^fn_r;
                    beats_q  <= (state == S_IDLE) ? CNT_W'(1) : cnt_next;
                    state    <= S_IDLE;
                end
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.beats     = beats_q;
endmodule

// File: tb/tb_logic_alu.sv
// tb/tb_logic_alu.sv - randomized and directed self-checking bench for logic_alu
module tb_logic_alu;
    logic       clk;
    logic       rst_n;
    logic       iv;
    logic [7:0] ia;
    logic [7:0] ib;
    logic [2:0] iop;
    logic       iacc;
    logic       ilast;
    logic       ordy;

    logic_alu_if #(.WIDTH(8), .CNT_W(8)) bus_w ();
    logic_alu_if #(.WIDTH(8), .CNT_W(2)) bus_n ();

    assign bus_w.in_valid  = iv;
    assign bus_w.a         = ia;
    assign bus_w.b         = ib;
    assign bus_w.op        = iop;
    assign bus_w.acc_mode  = iacc;
    assign bus_w.last      = ilast;
    assign bus_w.out_ready = ordy;
    assign bus_n.in_valid  = iv;
    assign bus_n.a         = ia;
    assign bus_n.b         = ib;
    assign bus_n.op        = iop;
    assign bus_n.acc_mode  = iacc;
    assign bus_n.last      = ilast;
    assign bus_n.out_ready = ordy;

    logic_alu #(.WIDTH(8), .CNT_W(8)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w.slave));
    logic_alu #(.WIDTH(8), .CNT_W(2)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~(x & z);
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    typedef struct {
        logic [7:0] y;
        int         n;
    } res_t;

    res_t       exp_q[$];
    logic [7:0] pkt_a[$];
    logic [7:0] pkt_b0;
    logic [2:0] pkt_op;
    int         n_results = 0;
    logic [7:0] last_y;
    logic       last_zero;
    logic       last_par;
    int         last_bw;
    int         last_bn;

    // Whole packet is kept and folded only when its last beat is accepted
    task automatic close_packet();
        res_t       r;
        logic [7:0] v;
        v = ref_f(pkt_a[0], pkt_b0, pkt_op);
        for (int i = 1; i < pkt_a.size(); i++) v = ref_f(v, pkt_a[i], pkt_op);
        r.y = v;
        r.n = pkt_a.size();
        exp_q.push_back(r);
        pkt_a.delete();
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [2:0] o, input logic am, input logic la, input logic rd);
        res_t e;
        int   en;
        @(negedge clk);
        rst_n = r; iv = v; ia = aa; ib = bb; iop = o; iacc = am; ilast = la; ordy = rd;
        #1;
        chk("in_ready", 32'(bus_w.in_ready), 32'(r && (exp_q.size() == 0 || rd)));
        chk("in_ready_n", 32'(bus_n.in_ready), 32'(r && (exp_q.size() == 0 || rd)));
        chk("out_valid", 32'(bus_w.out_valid), 32'(exp_q.size() != 0));
        chk("out_valid_n", 32'(bus_n.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e  = exp_q[0];
            en = (e.n > 3) ? 3 : e.n;
            chk("y", 32'(bus_w.y), 32'(e.y));
            chk("y_n", 32'(bus_n.y), 32'(e.y));
            chk("zero", 32'(bus_w.zero), 32'(e.y == 8'h00));
            chk("parity", 32'(bus_w.parity), 32'($countones(e.y) % 2));
            chk("beats", 32'(bus_w.beats), 32'((e.n > 255) ? 255 : e.n));
            chk("beats_n", 32'(bus_n.beats), 32'(en));
            if (rd && r) begin
                last_y    = bus_w.y;
                last_zero = bus_w.zero;
                last_par  = bus_w.parity;
                last_bw   = int'(bus_w.beats);
                last_bn   = int'(bus_n.beats);
                n_results++;
                void'(exp_q.pop_front());
            end
        end
        if (!r) begin
            exp_q.delete();
            pkt_a.delete();
        end else if (v && bus_w.in_ready) begin
            if (pkt_a.size() == 0) begin
                pkt_b0 = bb;
                pkt_op = o;
                pkt_a.push_back(aa);
                if (!am || la) close_packet();
            end else begin
                pkt_a.push_back(aa);
                if (la) close_packet();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [7:0] tbl [8];
    int         base;

    initial begin
        rst_n = 1'b0; iv = 1'b0; ia = '0; ib = '0; iop = '0; iacc = 1'b0; ilast = 1'b0; ordy = 1'b0;
        tbl = '{8'h4A, 8'hDF, 8'hB5, 8'h20, 8'h95, 8'h6A, 8'hCA, 8'h35};
        step(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rst_valid", 32'(bus_w.out_valid), 32'd0);
        chk("rst_y", 32'(bus_w.y), 32'd0);
        chk("rst_beats", 32'(bus_w.beats), 32'd0);
        chk("rst_ready", 32'(bus_w.in_ready), 32'd0);

        // Per-beat, every opcode, back to back
        for (int i = 0; i < 9; i++) begin
            step(1'b1, i < 8, 8'hCA, 8'h5F, 3'(i), 1'b0, 1'b0, 1'b1);
            if (i > 0) begin
                chk("op_tbl_y", 32'(last_y), 32'(tbl[i-1]));
                chk("op_tbl_beats", 32'(last_bw), 32'd1);
            end
        end

        // Accumulate XOR; ops on later beats must be ignored
        base = n_results;
        step(1'b1, 1'b1, 8'h01, 8'h02, 3'd4, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h04, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h08, 8'hFF, 3'd7, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h10, 8'hFF, 3'd1, 1'b1, 1'b1, 1'b1);
        idle(2);
        chk("acc_count", 32'(n_results - base), 32'd1);
        chk("acc_y", 32'(last_y), 32'h1F);
        chk("acc_beats", 32'(last_bw), 32'd4);
        chk("acc_parity", 32'(last_par), 32'd1);
        chk("acc_zero", 32'(last_zero), 32'd0);

        // Backpressure: result held, inputs stalled
        step(1'b1, 1'b1, 8'h3C, 8'hF0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 8'hAA, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b0);
            chk("bp_ready", 32'(bus_w.in_ready), 32'd0);
            chk("bp_hold_y", 32'(bus_w.y), 32'h30);
        end
        step(1'b1, 1'b1, 8'hAA, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b1);
        chk("bp_release_y", 32'(last_y), 32'h30);
        step(1'b1, 1'b1, 8'h0F, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        chk("bp_next_y", 32'(last_y), 32'hAF);
        idle(2);
        chk("bp_flow_y", 32'(last_y), 32'hF0);

        // Reset mid-packet discards the partial fold
        step(1'b1, 1'b1, 8'h55, 8'h33, 3'd1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h80, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(bus_w.out_valid), 32'd0);
        chk("mid_rst_y", 32'(bus_w.y), 32'd0);
        chk("mid_rst_flags", 32'({bus_w.zero, bus_w.parity}), 32'd0);
        chk("mid_rst_beats", 32'(bus_w.beats), 32'd0);
        step(1'b1, 1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1, 1'b1, 1'b1);
        idle(1);
        chk("post_rst_y", 32'(last_y), 32'h0F);
        chk("post_rst_beats", 32'(last_bw), 32'd1);

        // Six-beat OR packet saturates the narrow counter
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 8'(1 << i), 8'h00, 3'd1, 1'b1, i == 5, 1'b1);
        idle(1);
        chk("sat_beats_n", 32'(last_bn), 32'd3);
        chk("sat_beats_w", 32'(last_bw), 32'd6);
        chk("sat_y", 32'(last_y), 32'h3F);

        // AND producing zero
        step(1'b1, 1'b1, 8'hF0, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("zero_y", 32'(last_y), 32'h00);
        chk("zero_flag", 32'(last_zero), 32'd1);
        chk("zero_parity", 32'(last_par), 32'd0);

        // Randomized traffic with backpressure, long packets and occasional reset
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom), 8'($urandom), 3'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        idle(4);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
